free_list: RTL and testbench
============================

// Module: free_list
// PURPOSE
//  N-way circular free list of physical register tags for the out-of-order core.
//  Dispatch pulls new destination tags from it; the ROB sends retired Told tags back into it.
//  Sits between ROB retire (retire_told/retire_valid) and dispatch/rename (rob_packet_dis.tag).
//  At reset: arch reg i maps to phys i, and phys 0 is reserved for x0.
// PARAMETERS
//  N_WAY       `N_WAY (3)               superscalar width
//  N_PHYS_REG  64                       physical registers
//  N_ARCH_REG  32                       architectural registers
//  TAG_W       `CDB_BITS (6)            tag width, $clog2(N_PHYS_REG)
//  DEPTH       N_PHYS_REG-N_ARCH_REG    entries (32)
// PORTS
//  clock          in   1                system clock, rising edge
//  reset          in   1                asynchronous, ACTIVE-LOW reset
//  dispatch_req   in   N_WAY            slot i requests a new tag this cycle
//  free_tag       out  N_WAY*TAG_W      tag offered to slot i
//  free_valid     out  N_WAY            slot i granted; tag is consumed at clock edge
//  retire_valid   in   N_WAY            slot i retires this cycle
//  retire_told    in   N_WAY*TAG_W      Told of retiring slot i; returned to the list
//  avail          out  $clog2(N_WAY)+1  min(free_count, N_WAY); drives dispatch stall
//  free_count     out  $clog2(DEPTH)+1  entries currently free
//  overflow_err   out  1                sticky: a push was dropped because the list was full
// BEHAVIOUR
//  Reset (reset==0, async): entries[k] = N_ARCH_REG+k; head = tail = 0; count = DEPTH; overflow_err = 0.
//   While reset==0: free_valid = 0, avail = 0, free_count = DEPTH.
//   Reset asserted mid-operation discards all state immediately.
//  Grant (combinational from registered state):
//   Requesting slots are ranked in slot order; the j-th requester (j = 0..) is granted iff j < count.
//   A granted slot gets free_tag = entries[(head+j) % DEPTH].
//   Non-requesting or ungranted slots: free_valid = 0; free_tag = don't-care, held at the head-based value.
//  Pop (clock edge): head += number of grants, mod DEPTH.
//  Push (clock edge): retiring slots with retire_told != 0 are compacted in slot order.
//   They are written to entries[(tail+m) % DEPTH]; then tail += pushes, mod DEPTH.
//   retire_told == 0 (x0 mapping) is ignored, never pushed.
//  Count: count_next = count - grants + pushes.
//  No same-cycle bypass: tags pushed in cycle t are grantable from cycle t+1.
//   Grants are therefore limited by the registered count even when pushes occur.
//  Full: if count - grants + m would exceed DEPTH, push m and all later pushes that cycle are dropped.
//   Dropped pushes set overflow_err. This is a protocol error, cleared only by reset.
//  Head and tail wrap modulo DEPTH; DEPTH is not required to be a power of two.
//  Latency: grant 0 cycles (same cycle as dispatch_req); returned tag reusable 1 cycle after retire.
// STRUCTURE
//  Shared package sys_defs: `N_WAY, `CDB_BITS, N_PHYS_REG, N_ARCH_REG.
//   Add FL_DEPTH and typedef logic [`CDB_BITS-1:0] PHYS_TAG.
//  Sub-module slot_compact #(N_WAY): valid vector -> per-slot prefix index and total popcount.
//   Instantiated twice: dispatch grant ranking and retire push ranking.
//  Storage: DEPTH x TAG_W flop array, head/tail pointers, count register, overflow flop.
// TESTING
//  1 Release reset -> free_count=32, avail=3, free_tag={32,33,34}, free_valid=0 until requests arrive.
//  2 dispatch_req=111 for 2 cycles -> grants 32,33,34 then 35,36,37; free_count=26.
//  3 dispatch_req=101 -> slot0=38, slot1 free_valid=0, slot2=39; free_count drops by 2.
//  4 Drain to count=2, then req=111 -> slots 0,1 granted, slot 2 not; avail=2, then 0.
//  5 count=0, same cycle retire_told={3,6,9} + req=111 -> no grants; next cycle grants 3,6,9.
//  6 retire_told={0,14,0} valid=111 -> only 14 pushed (count+1).
//    Run head and tail past index 31 -> wrap-around keeps tag order.
//    Push when full -> push dropped, overflow_err=1.
//    Drop reset mid-burst -> state matches scenario 1.

Source files
------------

// File: rtl/free_list_pkg.sv
// Shared sizing for the rename free list: superscalar width, tag width and
// physical/architectural register counts.
package free_list_pkg;

  localparam int FL_N_WAY      = 3;
  localparam int FL_CDB_BITS   = 6;
  localparam int FL_N_PHYS_REG = 64;
  localparam int FL_N_ARCH_REG = 32;
  localparam int FL_DEPTH      = FL_N_PHYS_REG - FL_N_ARCH_REG;

  typedef logic [FL_CDB_BITS-1:0] phys_tag_t;

endpackage

// File: rtl/free_list_slot_compact.sv
// Ranks the set bits of a per-slot valid vector: each slot gets the number of
// valid slots below it, plus the total number of valid slots.
module slot_compact #(
  parameter int N_WAY = 3,
  parameter int IDX_W = $clog2(N_WAY + 1)
) (
  input  logic [N_WAY-1:0]       valid,
  output logic [N_WAY*IDX_W-1:0] idx,
  output logic [IDX_W-1:0]       total
);

  logic [IDX_W-1:0] acc_s;

  // Running prefix count in slot order.
  always_comb begin
    acc_s = '0;
    idx   = '0;
    for (int i = 0; i < N_WAY; i++) begin
      idx[i*IDX_W +: IDX_W] = acc_s;
      if (valid[i]) begin
        acc_s = acc_s + IDX_W'(1);
      end else begin
        acc_s = acc_s;
      end
    end
    total = acc_s;
  end

endmodule

// File: rtl/free_list.sv
// Circular free list of physical register tags: dispatch pops up to N_WAY
// tags per cycle, retiring Told tags (except x0) are pushed back.
module free_list
  import free_list_pkg::*;
#(
  parameter int N_WAY      = FL_N_WAY,
  parameter int N_PHYS_REG = FL_N_PHYS_REG,
  parameter int N_ARCH_REG = FL_N_ARCH_REG,
  parameter int TAG_W      = $clog2(N_PHYS_REG),
  parameter int DEPTH      = N_PHYS_REG - N_ARCH_REG
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [N_WAY-1:0]          dispatch_req,
  output logic [N_WAY*TAG_W-1:0]    free_tag,
  output logic [N_WAY-1:0]          free_valid,
  input  logic [N_WAY-1:0]          retire_valid,
  input  logic [N_WAY*TAG_W-1:0]    retire_told,
  output logic [$clog2(N_WAY):0]    avail,
  output logic [$clog2(DEPTH):0]    free_count,
  output logic                      overflow_err
);

  localparam int IDX_W = $clog2(N_WAY + 1);
  localparam int AV_W  = $clog2(N_WAY) + 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int PTR_W = $clog2(DEPTH);

  logic [TAG_W-1:0]       entries_q [DEPTH];
  logic [TAG_W-1:0]       entries_d [DEPTH];
  logic [PTR_W-1:0]       head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   overflow_q, overflow_d;

  logic [N_WAY*IDX_W-1:0] req_idx_s, push_idx_s;
  logic [IDX_W-1:0]       req_total_s, push_total_s;
  logic [N_WAY-1:0]       push_req_s;
  logic [CNT_W-1:0]       n_grant_s, n_push_s, room_s;
  logic                   drop_s;
  logic [IDX_W-1:0]       g_rank_s, p_rank_s;

  // Pointer advance modulo DEPTH; off never exceeds N_WAY so one subtract suffices.
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                input logic [CNT_W-1:0] off);
    logic [CNT_W:0] sum;
    sum = (CNT_W+1)'(base) + (CNT_W+1)'(off);
    if (sum >= (CNT_W+1)'(DEPTH)) begin
      sum = sum - (CNT_W+1)'(DEPTH);
    end else begin
      sum = sum;
    end
    return sum[PTR_W-1:0];
  endfunction

  slot_compact #(.N_WAY(N_WAY), .IDX_W(IDX_W)) u_grant_rank (
    .valid (dispatch_req),
    .idx   (req_idx_s),
    .total (req_total_s)
  );

  slot_compact #(.N_WAY(N_WAY), .IDX_W(IDX_W)) u_push_rank (
    .valid (push_req_s),
    .idx   (push_idx_s),
    .total (push_total_s)
  );

  // Retire slots carrying x0 never return a tag.
  always_comb begin
    push_req_s = '0;
    for (int i = 0; i < N_WAY; i++) begin
      push_req_s[i] = retire_valid[i] & (retire_told[i*TAG_W +: TAG_W] != '0);
    end
  end

  // Grants come only from the registered count; same-cycle pushes are not bypassed.
  always_comb begin
    free_tag   = '0;
    free_valid = '0;
    g_rank_s   = '0;
    for (int i = 0; i < N_WAY; i++) begin
      g_rank_s = req_idx_s[i*IDX_W +: IDX_W];
      if (dispatch_req[i]) begin
        free_tag[i*TAG_W +: TAG_W] = entries_q[wrap_add(head_q, CNT_W'(g_rank_s))];
      end else begin
        free_tag[i*TAG_W +: TAG_W] = entries_q[wrap_add(head_q, CNT_W'(i))];
      end
      if (reset && dispatch_req[i] && (CNT_W'(g_rank_s) < count_q)) begin
        free_valid[i] = 1'b1;
      end else begin
        free_valid[i] = 1'b0;
      end
    end
    if (!reset) begin
      n_grant_s = '0;
      avail     = '0;
    end else begin
      n_grant_s = (CNT_W'(req_total_s) < count_q) ? CNT_W'(req_total_s) : count_q;
      avail     = (count_q < CNT_W'(N_WAY)) ? AV_W'(count_q) : AV_W'(N_WAY);
    end
  end

  // Pushes are accepted in slot order until the list would exceed DEPTH.
  always_comb begin
    entries_d = entries_q;
    p_rank_s  = '0;
    room_s    = CNT_W'(DEPTH) - count_q + n_grant_s;
    n_push_s  = (CNT_W'(push_total_s) < room_s) ? CNT_W'(push_total_s) : room_s;
    drop_s    = CNT_W'(push_total_s) > room_s;
    for (int i = 0; i < N_WAY; i++) begin
      p_rank_s = push_idx_s[i*IDX_W +: IDX_W];
      if (push_req_s[i] && (CNT_W'(p_rank_s) < room_s)) begin
        entries_d[wrap_add(tail_q, CNT_W'(p_rank_s))] = retire_told[i*TAG_W +: TAG_W];
      end else begin
        entries_d = entries_d;
      end
    end
    head_d     = wrap_add(head_q, n_grant_s);
    tail_d     = wrap_add(tail_q, n_push_s);
    count_d    = count_q - n_grant_s + n_push_s;
    overflow_d = overflow_q | drop_s;
  end

  // State registers; reset refills the list with the tags above the arch map.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        entries_q[k] <= TAG_W'(N_ARCH_REG + k);
      end
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= CNT_W'(DEPTH);
      overflow_q <= 1'b0;
    end else begin
      entries_q  <= entries_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign free_count   = count_q;
  assign overflow_err = overflow_q;

endmodule

// File: tb/tb_free_list.sv
// Directed bench for free_list: stimulus queues expected grants, a negedge
// monitor pops and compares them whenever the DUT asserts free_valid.
module tb_free_list;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  dispatch_req = 3'b000;
  logic [2:0]  retire_valid = 3'b000;
  logic [17:0] retire_told = 18'd0;
  logic [17:0] free_tag;
  logic [2:0]  free_valid;
  logic [2:0]  avail;
  logic [5:0]  free_count;
  logic        overflow_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int slot;
    int tag;
  } exp_t;

  exp_t exp_q[$];

  free_list dut (
    .clock        (clock),
    .reset        (reset),
    .dispatch_req (dispatch_req),
    .free_tag     (free_tag),
    .free_valid   (free_valid),
    .retire_valid (retire_valid),
    .retire_told  (retire_told),
    .avail        (avail),
    .free_count   (free_count),
    .overflow_err (overflow_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic want(input int slot, input int tag);
    exp_t e;
    e.slot = slot;
    e.tag  = tag;
    exp_q.push_back(e);
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [2:0] req, input logic [2:0] rv, input logic [17:0] told);
    dispatch_req = req;
    retire_valid = rv;
    retire_told  = told;
  endtask

  // Monitor: every granted slot must match the next queued expectation.
  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        if (free_valid[i]) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_grant_slot", i, -1);
          end else begin
            e = exp_q.pop_front();
            chk("grant_slot", i, e.slot);
            chk("grant_tag", int'(free_tag[i*6 +: 6]), e.tag);
          end
        end
      end
      chk("missing_grants", exp_q.size(), 0);
      exp_q.delete();
    end
  end

  initial begin
    int t;
    #12;
    chk("rst_free_valid", int'(free_valid), 0);
    chk("rst_avail", int'(avail), 0);
    chk("rst_free_count", int'(free_count), 32);
    chk("rst_overflow", int'(overflow_err), 0);
    #10 reset = 1'b1;
    tick;
    chk("idle_free_count", int'(free_count), 32);
    chk("idle_avail", int'(avail), 3);
    chk("idle_free_tag", int'(free_tag), int'({6'd34, 6'd33, 6'd32}));
    chk("idle_free_valid", int'(free_valid), 0);

    // two full-width dispatch cycles
    drive(3'b111, 3'b000, 18'd0);
    want(0, 32); want(1, 33); want(2, 34);
    tick;
    want(0, 35); want(1, 36); want(2, 37);
    tick;
    drive(3'b000, 3'b000, 18'd0);
    chk("s2_free_count", int'(free_count), 26);

    // sparse request skips slot 1
    drive(3'b101, 3'b000, 18'd0);
    want(0, 38); want(2, 39);
    tick;
    drive(3'b000, 3'b000, 18'd0);
    chk("s3_free_count", int'(free_count), 24);

    // drain to two, then over-request
    t = 40;
    drive(3'b111, 3'b000, 18'd0);
    for (int c = 0; c < 7; c++) begin
      want(0, t); want(1, t + 1); want(2, t + 2);
      t = t + 3;
      tick;
    end
    drive(3'b001, 3'b000, 18'd0);
    want(0, 61);
    tick;
    drive(3'b000, 3'b000, 18'd0);
    chk("s4_free_count", int'(free_count), 2);
    chk("s4_avail2", int'(avail), 2);
    drive(3'b111, 3'b000, 18'd0);
    want(0, 62); want(1, 63);
    tick;
    drive(3'b000, 3'b000, 18'd0);
    chk("s4_empty_count", int'(free_count), 0);
    chk("s4_avail0", int'(avail), 0);

    // empty list: same-cycle retire is not bypassed
    drive(3'b111, 3'b111, {6'd9, 6'd6, 6'd3});
    tick;
    chk("s5_count_after_push", int'(free_count), 3);
    drive(3'b111, 3'b000, 18'd0);
    want(0, 3); want(1, 6); want(2, 9);
    tick;
    drive(3'b000, 3'b000, 18'd0);
    chk("s5_free_count", int'(free_count), 0);

    // x0 returns are ignored
    drive(3'b000, 3'b111, {6'd0, 6'd14, 6'd0});
    tick;
    drive(3'b000, 3'b000, 18'd0);
    chk("s6_free_count", int'(free_count), 1);
    drive(3'b001, 3'b000, 18'd0);
    want(0, 14);
    tick;
    drive(3'b000, 3'b000, 18'd0);
    chk("s6_drained", int'(free_count), 0);

    // fill across the wrap point; the 33rd push is dropped
    for (int c = 0; c < 11; c++) begin
      drive(3'b000, 3'b111, {6'(3*c + 3), 6'(3*c + 2), 6'(3*c + 1)});
      if (c == 10) chk("pre_overflow", int'(overflow_err), 0);
      tick;
    end
    drive(3'b000, 3'b000, 18'd0);
    chk("full_overflow", int'(overflow_err), 1);
    chk("full_count", int'(free_count), 32);
    chk("full_avail", int'(avail), 3);

    // drain in order through the wrap
    t = 1;
    drive(3'b111, 3'b000, 18'd0);
    for (int c = 0; c < 10; c++) begin
      want(0, t); want(1, t + 1); want(2, t + 2);
      t = t + 3;
      tick;
    end
    drive(3'b011, 3'b000, 18'd0);
    want(0, 31); want(1, 32);
    tick;
    drive(3'b000, 3'b000, 18'd0);
    chk("wrap_count", int'(free_count), 0);
    chk("overflow_sticky", int'(overflow_err), 1);

    // reset mid-burst
    drive(3'b000, 3'b111, {6'd11, 6'd7, 6'd5});
    tick;
    drive(3'b111, 3'b111, {6'd15, 6'd13, 6'd12});
    want(0, 5); want(1, 7); want(2, 11);
    tick;
    drive(3'b111, 3'b000, 18'd0);
    #1 reset = 1'b0;
    #1;
    chk("mid_rst_free_valid", int'(free_valid), 0);
    chk("mid_rst_avail", int'(avail), 0);
    chk("mid_rst_count", int'(free_count), 32);
    chk("mid_rst_overflow", int'(overflow_err), 0);
    drive(3'b000, 3'b000, 18'd0);
    #3 reset = 1'b1;
    tick;
    chk("post_rst_count", int'(free_count), 32);
    chk("post_rst_avail", int'(avail), 3);
    chk("post_rst_free_tag", int'(free_tag), int'({6'd34, 6'd33, 6'd32}));
    drive(3'b111, 3'b000, 18'd0);
    want(0, 32); want(1, 33); want(2, 34);
    tick;
    drive(3'b000, 3'b000, 18'd0);
    tick;
    chk("post_rst_final_count", int'(free_count), 29);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
